// File: rtl/squeeze_serializer.sv
// squeeze_serializer: output stage of the Haraka-S sponge.
// Accepts squeezed IN_WIDTH-bit rate blocks and emits them OUT_WIDTH bits per
// beat until out_len beats have been produced, requesting a new squeeze each
// time a block runs dry while beats are still owed.
// Optional build macro: SQUEEZE_MSB_FIRST_EN selects MSB-first beat order
// (default is LSB-first, matching the deserializer's packing).
module squeeze_serializer #(
  parameter int IN_WIDTH  = 256,
  parameter int OUT_WIDTH = 8,
  parameter int LEN_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 clear,
  input  logic                 start,
  input  logic [LEN_WIDTH-1:0] out_len,
  input  logic [IN_WIDTH-1:0]  block_in,
  input  logic                 block_valid,
  output logic                 block_ready,
  output logic [OUT_WIDTH-1:0] serial_out,
  output logic                 serial_valid,
  input  logic                 serial_ready,
  output logic                 squeeze_req,
  output logic                 done
);

  localparam int BEATS = IN_WIDTH / OUT_WIDTH;
  localparam int PKT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [1:0] {IDLE, WAIT_BLOCK, SHIFT, DONE} state_t;

  state_t               state;
  logic [IN_WIDTH-1:0]  shreg;
  logic [LEN_WIDTH-1:0] remaining;
  logic [PKT_W-1:0]     pkt;

  // The current beat is always the outgoing end of the shift register, so it
  // is stable for as long as the downstream stalls.
`ifdef SQUEEZE_MSB_FIRST_EN
  assign serial_out = shreg[IN_WIDTH-1 -: OUT_WIDTH];
`else
  assign serial_out = shreg[OUT_WIDTH-1:0];
`endif

  // Control FSM with registered handshake/pulse outputs; last-beat test is on
  // the pre-decrement count so remaining never wraps.
  always_ff @(posedge clk) begin
    if (clear) begin
      state        <= IDLE;
      shreg        <= '0;
      remaining    <= '0;
      pkt          <= '0;
      block_ready  <= 1'b0;
      serial_valid <= 1'b0;
      squeeze_req  <= 1'b0;
      done         <= 1'b0;
    end else begin
      squeeze_req <= 1'b0;
      done        <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (out_len == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              remaining   <= out_len;
              state       <= WAIT_BLOCK;
              block_ready <= 1'b1;
            end
          end
        end
        WAIT_BLOCK: begin
          if (block_valid && block_ready) begin
            shreg        <= block_in;
            pkt          <= '0;
            state        <= SHIFT;
            block_ready  <= 1'b0;
            serial_valid <= 1'b1;
          end
        end
        SHIFT: begin
          if (serial_valid && serial_ready) begin
`ifdef SQUEEZE_MSB_FIRST_EN
            shreg <= {shreg[IN_WIDTH-OUT_WIDTH-1:0], {OUT_WIDTH{1'b0}}};
`else
            shreg <= {{OUT_WIDTH{1'b0}}, shreg[IN_WIDTH-1:OUT_WIDTH]};
`endif
            remaining <= remaining - LEN_WIDTH'(1);
            pkt       <= pkt + PKT_W'(1);
            if (remaining == LEN_WIDTH'(1)) begin
              // Leftover bytes of this block are simply dropped.
              state        <= DONE;
              serial_valid <= 1'b0;
              done         <= 1'b1;
            end else if (pkt == PKT_W'(BEATS - 1)) begin
              state        <= WAIT_BLOCK;
              serial_valid <= 1'b0;
              block_ready  <= 1'b1;
              squeeze_req  <= 1'b1;
            end
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_squeeze_serializer.sv
// Bench for squeeze_serializer (default LSB-first build). Expected beats come
// from a byte-stream model: the first out_len bytes of the supplied blocks
// taken back to back, byte 0 of each block at its LSB.
module tb_squeeze_serializer;

  logic         clk = 1'b0;
  logic         clear, start, block_valid, serial_ready;
  logic [15:0]  out_len;
  logic [255:0] block_in;
  logic         block_ready, serial_valid, squeeze_req, done;
  logic [7:0]   serial_out;

  int total = 0;
  int passed = 0;

  logic [255:0] blk [8];

  typedef struct {
    int len;
    int rmode;   // 0 full rate, 1 ready pattern 1,0,0,1, 2 random
    bit poke;    // pulse start (out_len=100) mid-SHIFT
    int exp_req;
  } vec_t;

  squeeze_serializer dut (
    .clk(clk), .clear(clear), .start(start), .out_len(out_len),
    .block_in(block_in), .block_valid(block_valid), .block_ready(block_ready),
    .serial_out(serial_out), .serial_valid(serial_valid),
    .serial_ready(serial_ready), .squeeze_req(squeeze_req), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
  endtask

  task automatic set_blocks(input bit rnd);
    for (int b = 0; b < 8; b++)
      for (int i = 0; i < 32; i++)
        blk[b][8*i +: 8] = rnd ? 8'($urandom) :
                           (b == 0) ? 8'(i) : (b == 1) ? 8'(8'h80 + i) : 8'($urandom);
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_block_ready"}, block_ready, 0);
    check({tag, "_serial_valid"}, serial_valid, 0);
    check({tag, "_serial_out"}, serial_out, 0);
    check({tag, "_squeeze_req"}, squeeze_req, 0);
    check({tag, "_done"}, done, 0);
  endtask

  // Entered at a negedge with the DUT idle; drives start this cycle.
  task automatic run(input int len, input int rmode, input bit poke, input int exp_req);
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int nblk = 0, reqs = 0, dones = 0, cyc = 0, due = -1;
    int first = -1, last = -1;
    bit stall = 0, poked = 0, fin = 0, bad_stall = 0, bad_req = 0;
    logic [7:0] held = '0;
    for (int i = 0; i < len; i++) exp_q.push_back(blk[i/32][8*(i%32) +: 8]);
    start = 1'b1; out_len = 16'(len);
    @(negedge clk); cyc = 1;
    start = 1'b0; out_len = 16'($urandom);
    if (len == 0) due = 1;
    while (cyc < 3000 && !fin) begin
      if (done) begin
        dones++;
        check("done_timing", cyc, due);
        fin = 1;
      end
      if (squeeze_req) begin
        reqs++;
        if (!block_ready) bad_req = 1;
      end
      if (stall && (!serial_valid || serial_out != held)) bad_stall = 1;
      block_valid = block_ready && (rmode != 2 || $urandom_range(0, 3) != 0);
      block_in = blk[nblk % 8];
      if (block_valid) nblk++;
      case (rmode)
        0: serial_ready = 1'b1;
        1: serial_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: serial_ready = 1'($urandom);
      endcase
      if (serial_valid && serial_ready) begin
        got_q.push_back(serial_out);
        if (first < 0) first = cyc;
        last = cyc;
        if (got_q.size() == len) due = cyc + 1;
      end
      stall = serial_valid && !serial_ready;
      held = serial_out;
      if (poke && !poked && got_q.size() == 3) begin
        start = 1'b1; out_len = 16'd100; poked = 1;
      end else start = 1'b0;
      @(negedge clk); cyc++;
    end
    block_valid = 1'b0; serial_ready = 1'b0;
    check("done_count", dones, 1);
    check("squeeze_req_count", reqs, exp_req);
    check("squeeze_req_with_block_ready", bad_req, 0);
    check("stall_stable", bad_stall, 0);
    check("beat_count", got_q.size(), len);
    for (int i = 0; i < len && i < got_q.size(); i++)
      check($sformatf("beat[%0d]", i), got_q[i], exp_q[i]);
    if (rmode == 0 && len > 0 && len <= 32) check("back_to_back", last - first, len - 1);
    check("post_done_low", done, 0);
    check("post_idle_valid", serial_valid | block_ready, 0);
  endtask

  initial begin
    vec_t tbl[5];
    tbl[0] = '{len: 32, rmode: 0, poke: 0, exp_req: 0};
    tbl[1] = '{len: 40, rmode: 0, poke: 0, exp_req: 1};
    tbl[2] = '{len: 32, rmode: 1, poke: 0, exp_req: 0};
    tbl[3] = '{len: 0,  rmode: 0, poke: 0, exp_req: 0};
    tbl[4] = '{len: 20, rmode: 0, poke: 1, exp_req: 0};

    clear = 1'b1; start = 1'b0; out_len = '0; block_in = '0;
    block_valid = 1'b0; serial_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_idle_zero("reset");
    clear = 1'b0;

    foreach (tbl[k]) begin
      set_blocks(0);
      run(tbl[k].len, tbl[k].rmode, tbl[k].poke, tbl[k].exp_req);
    end

    // clear in SHIFT after 5 beats drops everything; a start right after works
    set_blocks(0);
    start = 1'b1; out_len = 16'd32;
    @(negedge clk); start = 1'b0;
    check("clr_block_ready", block_ready, 1);
    block_valid = 1'b1; block_in = blk[0];
    @(negedge clk); block_valid = 1'b0; serial_ready = 1'b1;
    repeat (5) @(negedge clk);
    check("clr_mid_beat", serial_out, 5);
    clear = 1'b1; serial_ready = 1'b0;
    @(negedge clk);
    check_idle_zero("clear");
    // clear and start together: clear wins
    start = 1'b1; out_len = 16'd5;
    @(negedge clk);
    check("clear_beats_start", block_ready, 0);
    clear = 1'b0; start = 1'b0;
    set_blocks(1);
    run(4, 0, 0, 0);

    // randomized lengths, stalls and block delays
    for (int r = 0; r < 12; r++) begin
      int len = $urandom_range(1, 130);
      set_blocks(1);
      run(len, 2, 0, (len + 31) / 32 - 1);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
